controle_temporizador: RTL and testbench
========================================

CONTROLE_TEMPORIZADOR -- requirements
Module: controle_temporizador

Interface
REQ-001 The block SHALL have one parameter: FIM_TICKS, default 3, number of tick pulses spent in FIM before returning to OCIOSO (range 1..15).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-cycle enable pulse (e.g. 1 Hz) from an external divider
iniciar  input  1  level; start or resume the countdown
pausar  input  1  level; pause the countdown
carga_dez  input  2  preset tens digit, 0..3
carga_unid  input  4  preset units digit, BCD 0..9
estado_out  output  2  FSM state code for the 7-segment state decoder
dez_out  output  2  current tens digit
unid_out  output  4  current units digit, BCD
fim  output  1  one-cycle pulse on entry to FIM

Function
REQ-003 States and codes SHALL be: OCIOSO=2'b00, CONTANDO=2'b01, PAUSA=2'b10, FIM=2'b11; estado_out SHALL equal the state register.
REQ-004 In OCIOSO the counter SHALL load {carga_dez, min(carga_unid,9)} every cycle; any carga_unid value of 10..15 SHALL be clamped to 9.
REQ-005 OCIOSO -> CONTANDO SHALL occur on the first cycle with iniciar=1, pausar=0, and a loaded value other than 00; a preset of 00 with iniciar=1 SHALL go directly to FIM.
REQ-006 In CONTANDO, each cycle with tick=1 SHALL decrement the BCD value by one: if unid>0 then unid-1, else unid=9 and dez-1.
REQ-007 When tick=1 and the value is 01, the counter SHALL become 00 and the state SHALL become FIM in that same cycle; fim SHALL be 1 in the following cycle only.
REQ-008 CONTANDO -> PAUSA SHALL occur on pausar=1 and has priority over a simultaneous tick (no decrement in that cycle).
REQ-009 PAUSA SHALL hold the counter; PAUSA -> CONTANDO SHALL occur on iniciar=1 with pausar=0; pausar=1 SHALL dominate iniciar=1.
REQ-010 In FIM the counter SHALL hold 00; after FIM_TICKS tick pulses it SHALL return to OCIOSO and reload the preset.
REQ-011 Decrement latency SHALL be one cycle: outputs change on the clock edge at which tick=1 was sampled.
REQ-012 dez_out/unid_out SHALL never leave the set {dez 0..3, unid 0..9}; there SHALL be no wrap below 00.
REQ-013 Inputs SHALL be sampled synchronously; the block does not synchronise or debounce iniciar/pausar (the upstream stage owns that).

Reset
REQ-014 With rst_n=0, the block SHALL immediately, without a clock edge, set state=OCIOSO, dez_out=0, unid_out=0, fim=0, and FIM tick counter=0.
REQ-015 Reset asserted mid-count or in PAUSA/FIM SHALL abort the operation with no fim pulse; after release the block SHALL be in OCIOSO and load the preset on the first edge.

Structure
REQ-016 State codes (OCIOSO, CONTANDO, PAUSA, FIM) and the BCD max constant 9 SHALL live in a shared package used by this block and the display decoder.
REQ-017 The BCD two-digit down-counter SHALL be one sub-module, contador_bcd_dec (load, enable, zero flag); the FSM and FIM hold counter SHALL stay in the top module.

Verification
REQ-018 Preset dez=1, unid=2; iniciar, then 12 ticks -> values 11,10,09..01,00; state 01 then 11 at 00; fim high exactly 1 cycle.
REQ-019 Preset dez=2, unid=0 in CONTANDO; one tick -> dez=1, unid=9 (borrow).
REQ-020 At value 07 in CONTANDO, drive pausar=1 and tick=1 in the same cycle -> state 10, value stays 07; 5 ticks -> still 07; iniciar -> state 01, next tick gives 06.
REQ-021 carga_unid=4'hC, carga_dez=0 in OCIOSO -> unid_out=9; preset 00 with iniciar -> direct to FIM, fim pulses once.
REQ-022 In FIM with FIM_TICKS=3, 3 ticks -> state 00 and preset reloaded; drop rst_n mid-count at value 05 -> outputs 0/0/0 immediately, no fim pulse.

Source files
------------

// File: rtl/controle_temporizador_pkg.sv
// Shared definitions for the countdown timer and its 7-segment state decoder.
//   estado_t  : FSM state codes (also the code shown on the state display)
//   BCD_MAX   : largest legal BCD digit
//   clamp_bcd : forces an out-of-range BCD nibble (10..15) down to 9
package controle_temporizador_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONTANDO = 2'b01,
    PAUSA    = 2'b10,
    FIM      = 2'b11
  } estado_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/controle_temporizador_if.sv
// Signal bundle between the control panel (master) and the timer (slave).
//   tick        : one-cycle enable pulse from an external divider
//   iniciar     : level, start or resume the countdown
//   pausar      : level, pause the countdown (dominates iniciar)
//   carga_dez   : preset tens digit 0..3
//   carga_unid  : preset units digit, BCD (10..15 clamped to 9)
//   estado_out  : current FSM state code
//   dez_out     : current tens digit
//   unid_out    : current units digit, BCD
//   fim         : one-cycle pulse on entry to FIM
// There is no valid/ready handshake here: inputs are plain levels/pulses
// sampled on every rising clock edge, outputs are registered.
interface controle_temporizador_if;

  logic       tick;
  logic       iniciar;
  logic       pausar;
  logic [1:0] carga_dez;
  logic [3:0] carga_unid;
  logic [1:0] estado_out;
  logic [1:0] dez_out;
  logic [3:0] unid_out;
  logic       fim;

  modport master (
    output tick, iniciar, pausar, carga_dez, carga_unid,
    input  estado_out, dez_out, unid_out, fim
  );

  modport slave (
    input  tick, iniciar, pausar, carga_dez, carga_unid,
    output estado_out, dez_out, unid_out, fim
  );

endinterface

// File: rtl/controle_temporizador_contador_bcd_dec.sv
// Two-digit BCD down-counter (tens 0..3, units 0..9).
//   clk, rst_n : clock, asynchronous active-low reset (clears to 00)
//   load       : copy load_dez/load_unid into the counter (wins over enable)
//   enable     : decrement by one; holds at 00, never wraps below
//   load_dez   : tens value to load
//   load_unid  : units value to load, expected already clamped to 0..9
//   dez, unid  : current value
//   zero       : high while the value is 00
module contador_bcd_dec
  import controle_temporizador_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       enable,
  input  logic [1:0] load_dez,
  input  logic [3:0] load_unid,
  output logic [1:0] dez,
  output logic [3:0] unid,
  output logic       zero
);

  assign zero = (dez == 2'd0) && (unid == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dez  <= 2'd0;
      unid <= 4'd0;
    end else if (load) begin
      dez  <= load_dez;
      unid <= load_unid;
    end else if (enable && !zero) begin
      if (unid != 4'd0) begin
        unid <= unid - 4'd1;
      end else begin
        // Borrow from the tens digit; zero guard above keeps dez > 0 here.
        unid <= BCD_MAX;
        dez  <= dez - 2'd1;
      end
    end
  end

endmodule

// File: rtl/controle_temporizador.sv
// Countdown timer control: OCIOSO (load preset) -> CONTANDO (count on tick)
// <-> PAUSA, then FIM for FIM_TICKS ticks before returning to OCIOSO.
//   FIM_TICKS  : tick pulses spent in FIM (1..15)
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : slave side of controle_temporizador_if (inputs, digits,
//                state code and fim pulse)
module controle_temporizador
  import controle_temporizador_pkg::*;
#(
  parameter int FIM_TICKS = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  controle_temporizador_if.slave      bus
);

  localparam logic [3:0] FIM_LAST = 4'(FIM_TICKS - 1);

  estado_t    state, next_state;
  logic [3:0] fim_cnt, fim_cnt_next;
  logic       fim_q;

  logic       cnt_load, cnt_en;
  logic [1:0] dez;
  logic [3:0] unid;
  logic       zero;

  logic [3:0] preset_unid;
  logic       preset_zero;
  logic       is_one;

  assign preset_unid = clamp_bcd(bus.carga_unid);
  assign preset_zero = (bus.carga_dez == 2'd0) && (preset_unid == 4'd0);
  assign is_one      = (dez == 2'd0) && (unid == 4'd1);

  contador_bcd_dec u_contador (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .enable    (cnt_en),
    .load_dez  (bus.carga_dez),
    .load_unid (preset_unid),
    .dez       (dez),
    .unid      (unid),
    .zero      (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OCIOSO;
      fim_cnt <= 4'd0;
      fim_q   <= 1'b0;
    end else begin
      state   <= next_state;
      fim_cnt <= fim_cnt_next;
      // Registered pulse: high for exactly the first cycle spent in FIM.
      fim_q   <= (next_state == FIM) && (state != FIM);
    end
  end

  always_comb begin
    next_state   = state;
    fim_cnt_next = 4'd0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    case (state)
      OCIOSO: begin
        cnt_load = 1'b1;
        // Decision uses the clamped preset, which is what gets loaded on
        // this same edge, so the counter always matches the chosen state.
        if (bus.iniciar && !bus.pausar) begin
          next_state = preset_zero ? FIM : CONTANDO;
        end
      end
      CONTANDO: begin
        if (bus.pausar) begin
          next_state = PAUSA;
        end else if (zero) begin
          next_state = FIM;
        end else if (bus.tick) begin
          cnt_en = 1'b1;
          if (is_one) begin
            next_state = FIM;
          end
        end
      end
      PAUSA: begin
        if (!bus.pausar && bus.iniciar) begin
          next_state = CONTANDO;
        end
      end
      FIM: begin
        fim_cnt_next = fim_cnt;
        if (bus.tick) begin
          if (fim_cnt >= FIM_LAST) begin
            next_state   = OCIOSO;
            fim_cnt_next = 4'd0;
            // Reload on the exit edge so the preset appears with OCIOSO.
            cnt_load     = 1'b1;
          end else begin
            fim_cnt_next = fim_cnt + 4'd1;
          end
        end
      end
      default: next_state = OCIOSO;
    endcase
  end

  assign bus.estado_out = state;
  assign bus.dez_out    = dez;
  assign bus.unid_out   = unid;
  assign bus.fim        = fim_q;

endmodule

// File: tb/tb_controle_temporizador.sv
// Directed self-checking bench for controle_temporizador (FIM_TICKS = 3).
// Observed vector layout: {estado[1:0], dez[1:0], unid[3:0], fim}.
module tb_controle_temporizador;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  controle_temporizador_if bus ();

  controle_temporizador #(.FIM_TICKS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_preset(input logic [1:0] d, input logic [3:0] u);
    bus.carga_dez  = d;
    bus.carga_unid = u;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [8:0] snap();
    return {bus.estado_out, bus.dez_out, bus.unid_out, bus.fim};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0] obs;
    rst_n = 1'b0;
    set_preset(2'd1, 4'd2);
    #2;
    obs = snap();
    checks++;
    if (obs !== 9'b00_00_0000_0) begin
      errors++;
      $display("FAIL reset_async got %b exp %b", obs, 9'b00_00_0000_0);
    end
    cyc();
    obs = snap();
    checks++;
    if (obs !== 9'b00_00_0000_0) begin
      errors++;
      $display("FAIL reset_held got %b exp %b", obs, 9'b00_00_0000_0);
    end
    rst_n = 1'b1;
    cyc();
    obs = snap();
    checks++;
    if (obs !== 9'b00_01_0010_0) begin
      errors++;
      $display("FAIL reset_first_load got %b exp %b", obs, 9'b00_01_0010_0);
    end
  endtask

  task automatic test_contagem();
    logic [8:0] obs, exp_v;
    int v;
    int pulses;
    pulses = 0;
    set_preset(2'd1, 4'd2);
    cyc();
    bus.iniciar = 1'b1;
    cyc();
    bus.iniciar = 1'b0;
    obs = snap();
    checks++;
    if (obs !== 9'b01_01_0010_0) begin
      errors++;
      $display("FAIL count_start got %b exp %b", obs, 9'b01_01_0010_0);
    end
    for (int i = 1; i <= 12; i++) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      v = 12 - i;
      exp_v = {(i == 12) ? 2'b11 : 2'b01, 2'(v / 10), 4'(v % 10), (i == 12)};
      obs = snap();
      if (obs[0]) pulses++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL count_tick%0d got %b exp %b", i, obs, exp_v);
      end
    end
    cyc();
    obs = snap();
    if (obs[0]) pulses++;
    checks++;
    if (obs !== 9'b11_00_0000_0) begin
      errors++;
      $display("FAIL count_fim_hold got %b exp %b", obs, 9'b11_00_0000_0);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL count_fim_pulses got %0d exp 1", pulses);
    end
    for (int t = 1; t <= 3; t++) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      exp_v = (t < 3) ? 9'b11_00_0000_0 : 9'b00_01_0010_0;
      obs = snap();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL fim_tick%0d got %b exp %b", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_borrow();
    logic [8:0] obs;
    set_preset(2'd2, 4'd0);
    cyc();
    bus.iniciar = 1'b1;
    cyc();
    bus.iniciar = 1'b0;
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    obs = snap();
    checks++;
    if (obs !== 9'b01_01_1001_0) begin
      errors++;
      $display("FAIL borrow got %b exp %b", obs, 9'b01_01_1001_0);
    end
    do_reset();
  endtask

  task automatic test_pausa();
    logic [8:0] obs;
    set_preset(2'd0, 4'd8);
    cyc();
    // pausar blocks the start from OCIOSO
    bus.iniciar = 1'b1;
    bus.pausar  = 1'b1;
    cyc();
    obs = snap();
    checks++;
    if (obs !== 9'b00_00_1000_0) begin
      errors++;
      $display("FAIL start_blocked got %b exp %b", obs, 9'b00_00_1000_0);
    end
    bus.pausar = 1'b0;
    cyc();
    bus.iniciar = 1'b0;
    bus.tick = 1'b1;
    cyc();
    obs = snap();
    checks++;
    if (obs !== 9'b01_00_0111_0) begin
      errors++;
      $display("FAIL pause_pre got %b exp %b", obs, 9'b01_00_0111_0);
    end
    bus.pausar = 1'b1;
    cyc();
    bus.tick   = 1'b0;
    bus.pausar = 1'b0;
    obs = snap();
    checks++;
    if (obs !== 9'b10_00_0111_0) begin
      errors++;
      $display("FAIL pause_priority got %b exp %b", obs, 9'b10_00_0111_0);
    end
    for (int i = 0; i < 5; i++) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      cyc();
    end
    obs = snap();
    checks++;
    if (obs !== 9'b10_00_0111_0) begin
      errors++;
      $display("FAIL pause_hold got %b exp %b", obs, 9'b10_00_0111_0);
    end
    bus.pausar  = 1'b1;
    bus.iniciar = 1'b1;
    cyc();
    obs = snap();
    checks++;
    if (obs !== 9'b10_00_0111_0) begin
      errors++;
      $display("FAIL pause_dominates got %b exp %b", obs, 9'b10_00_0111_0);
    end
    bus.pausar = 1'b0;
    cyc();
    bus.iniciar = 1'b0;
    obs = snap();
    checks++;
    if (obs !== 9'b01_00_0111_0) begin
      errors++;
      $display("FAIL resume got %b exp %b", obs, 9'b01_00_0111_0);
    end
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    obs = snap();
    checks++;
    if (obs !== 9'b01_00_0110_0) begin
      errors++;
      $display("FAIL resume_tick got %b exp %b", obs, 9'b01_00_0110_0);
    end
    do_reset();
  endtask

  task automatic test_clamp_zero();
    logic [8:0] obs, exp_v;
    set_preset(2'd0, 4'hC);
    cyc();
    obs = snap();
    checks++;
    if (obs !== 9'b00_00_1001_0) begin
      errors++;
      $display("FAIL clamp_0C got %b exp %b", obs, 9'b00_00_1001_0);
    end
    set_preset(2'd3, 4'hF);
    cyc();
    obs = snap();
    checks++;
    if (obs !== 9'b00_11_1001_0) begin
      errors++;
      $display("FAIL clamp_3F got %b exp %b", obs, 9'b00_11_1001_0);
    end
    set_preset(2'd0, 4'd0);
    cyc();
    bus.iniciar = 1'b1;
    cyc();
    bus.iniciar = 1'b0;
    obs = snap();
    checks++;
    if (obs !== 9'b11_00_0000_1) begin
      errors++;
      $display("FAIL zero_direct_fim got %b exp %b", obs, 9'b11_00_0000_1);
    end
    cyc();
    obs = snap();
    checks++;
    if (obs !== 9'b11_00_0000_0) begin
      errors++;
      $display("FAIL zero_fim_once got %b exp %b", obs, 9'b11_00_0000_0);
    end
    set_preset(2'd0, 4'd4);
    for (int t = 1; t <= 3; t++) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      cyc();
      exp_v = (t < 3) ? 9'b11_00_0000_0 : 9'b00_00_0100_0;
      obs = snap();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL zero_fim_tick%0d got %b exp %b", t, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] obs;
    int pulses;
    pulses = 0;
    set_preset(2'd0, 4'd7);
    cyc();
    bus.iniciar = 1'b1;
    cyc();
    bus.iniciar = 1'b0;
    bus.tick = 1'b1;
    cyc();
    cyc();
    bus.tick = 1'b0;
    obs = snap();
    checks++;
    if (obs !== 9'b01_00_0101_0) begin
      errors++;
      $display("FAIL mid_at05 got %b exp %b", obs, 9'b01_00_0101_0);
    end
    rst_n = 1'b0;
    #1;
    obs = snap();
    checks++;
    if (obs !== 9'b00_00_0000_0) begin
      errors++;
      $display("FAIL mid_async got %b exp %b", obs, 9'b00_00_0000_0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (bus.fim) pulses++;
    end
    rst_n = 1'b1;
    cyc();
    if (bus.fim) pulses++;
    obs = snap();
    checks++;
    if (obs !== 9'b00_00_0111_0) begin
      errors++;
      $display("FAIL mid_reload got %b exp %b", obs, 9'b00_00_0111_0);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_no_fim got %0d exp 0", pulses);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks      = 0;
    errors      = 0;
    bus.tick    = 1'b0;
    bus.iniciar = 1'b0;
    bus.pausar  = 1'b0;
    set_preset(2'd0, 4'd0);
    test_reset();
    test_contagem();
    test_borrow();
    test_pausa();
    test_clamp_zero();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
